// File: rtl/apb_arb_pkg.sv
// Shared state encoding, default widths and helpers for the APB arbiter/master.
package apb_arb_pkg;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_ADDRWIDTH      = 8;
  localparam int unsigned DEF_DATAWIDTH      = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } state_t;

  // Index width for a requester count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit at or above rr_ptr, with wrap.
module rr_picker
  import apb_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int unsigned j;
    logic        found;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      j = 32'(rr_ptr) + off;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req[IDX_W'(j)]) begin
        found             = 1'b1;
        pick[IDX_W'(j)]   = 1'b1;
        idx               = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/apb_arbiter_master.sv
// Round-robin arbiter and sole APB master sharing one slave among NUM_REQ requesters.
// Define APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES cycles without PREADY.
module apb_arbiter_master
  import apb_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned ADDRWIDTH      = DEF_ADDRWIDTH,
  parameter int unsigned DATAWIDTH      = DEF_DATAWIDTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDRWIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATAWIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             grant,
  output logic [NUM_REQ-1:0]             done,
  output logic                           done_err,
  output logic [DATAWIDTH-1:0]           rdata,
  output logic                           PSEL,
  output logic                           PENABLE,
  output logic                           PWRITE,
  output logic [ADDRWIDTH-1:0]           PADDR,
  output logic [DATAWIDTH-1:0]           PWDATA,
  input  logic [DATAWIDTH-1:0]           PRDATA,
  input  logic                           PREADY
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("apb_arbiter_master: unsupported parameter set");
  end

  state_t               state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     cur_idx;
  logic [NUM_REQ-1:0]   pick;
  logic [IDX_W-1:0]     pick_idx;
  logic                 timeout_c;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr),
    .pick   (pick),
    .idx    (pick_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] to_cnt;

  assign timeout_c = !PREADY && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts ACCESS cycles; held at zero outside ACCESS so each transfer starts fresh.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      to_cnt   <= '0;
      done_err <= 1'b0;
    end else begin
      done_err <= (state == ST_ACCESS) && timeout_c;
      if (state == ST_ACCESS) to_cnt <= to_cnt + 1'b1;
      else                    to_cnt <= '0;
    end
  end
`else
  assign timeout_c = 1'b0;
  assign done_err  = 1'b0;
`endif

  // Arbitration and APB sequencing; request fields are latched once in IDLE.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      cur_idx <= '0;
      grant   <= '0;
      done    <= '0;
      rdata   <= '0;
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            cur_idx <= pick_idx;
            grant   <= pick;
            PSEL    <= 1'b1;
            PWRITE  <= req_write[pick_idx];
            PADDR   <= req_addr[32'(pick_idx) * ADDRWIDTH +: ADDRWIDTH];
            PWDATA  <= req_wdata[32'(pick_idx) * DATAWIDTH +: DATAWIDTH];
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY || timeout_c) begin
            if (PREADY && !PWRITE) rdata <= PRDATA;
            done    <= grant;
            grant   <= '0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            rr_ptr  <= (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter_master.sv
// Self-checking bench for apb_arbiter_master driving a 256x32 APB RAM slave model.
// Abort checks are compiled in when APB_ARB_TIMEOUT_EN is defined.
module tb_apb_arbiter_master;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic            PCLK;
  logic            PRESET;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            done_err;
  logic [DW-1:0]   rdata;
  logic            PSEL;
  logic            PENABLE;
  logic            PWRITE;
  logic [AW-1:0]   PADDR;
  logic [DW-1:0]   PWDATA;
  logic [DW-1:0]   PRDATA;
  logic            PREADY;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int            idx;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    bit            err;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  // Slave RAM model with programmable wait states
  logic [DW-1:0] mem [256];
  int            acc_cnt;
  int            wait_states;
  bit            stuck;

  // Reference model state for the randomized phase
  bit            m_busy;
  int            m_owner;
  int            m_start;
  int            m_w;
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  int            m_rr;
  logic [DW-1:0] m_rdata;
  int            m_edge;
  logic [DW-1:0] mm [256];
  logic [N-1:0]  e_done;
  logic [N-1:0]  e_grant;
  bit            e_psel;
  bit            e_pen;
  bit            r_pend [N];

  apb_arbiter_master #(
    .NUM_REQ        (N),
    .ADDRWIDTH      (AW),
    .DATAWIDTH      (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req       (req),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .done_err  (done_err),
    .rdata     (rdata),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  function automatic logic [DW-1:0] init_word(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'h5A00_00C3;
  endfunction

  assign PRDATA = mem[PADDR];
  assign PREADY = PSEL && PENABLE && !stuck && (acc_cnt >= wait_states);

  always @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      acc_cnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (PSEL && PENABLE) begin
      if (PREADY) begin
        acc_cnt <= 0;
        if (PWRITE) mem[PADDR] <= PWDATA;
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]         = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    req       = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    stuck     = 1'b0;
    wait_states = 0;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  // One isolated transfer; request fields are scrambled after latching.
  task automatic do_xfer(input vec_t v);
    int lat;
    bit seen;
    wait_states = v.waits;
    @(posedge PCLK); #1;
    set_lane(v.idx, v.wr, v.addr, v.wdata);
    req = '0;
    req[v.idx] = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      @(posedge PCLK); #1;
      lat++;
      if (done != '0) begin
        seen = 1'b1;
      end else begin
        chk("xfer_psel", 64'(PSEL), 64'(1));
        chk("xfer_penable", 64'(PENABLE), 64'(lat > 1));
        chk("xfer_grant", 64'(grant), 64'(N'(1) << v.idx));
        chk("xfer_paddr", 64'(PADDR), 64'(v.addr));
        chk("xfer_pwrite", 64'(PWRITE), 64'(v.wr));
        if (v.wr) chk("xfer_pwdata", 64'(PWDATA), 64'(v.wdata));
      end
      if (lat == 1) set_lane(v.idx, !v.wr, ~v.addr, ~v.wdata);
    end
    chk("xfer_done", 64'(done), 64'(N'(1) << v.idx));
    chk("xfer_latency", 64'(lat), 64'(v.exp_lat));
    chk("xfer_done_err", 64'(done_err), 64'(v.err));
    chk("xfer_rdata", 64'(rdata), 64'(v.exp_rdata));
    chk("xfer_idle_psel", 64'(PSEL), 64'(0));
    req = '0;
  endtask

  // Raise a set of requests at once and confirm who wins; caller is off the clock edge.
  task automatic race(input logic [N-1:0] mask, input int exp_idx);
    int n;
    for (int i = 0; i < N; i++) set_lane(i, 1'b0, 8'(32'h20 + i), '0);
    wait_states = 0;
    req = mask;
    n = 0;
    while (grant == '0 && n < 10) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("race_grant", 64'(grant), 64'(N'(1) << exp_idx));
    req = '0;
    req[exp_idx] = 1'b1;
    n = 0;
    while (done == '0 && n < 10) begin
      @(posedge PCLK); #1;
      n++;
    end
    chk("race_done", 64'(done), 64'(N'(1) << exp_idx));
    req = '0;
  endtask

  // Transaction-level prediction of outputs after the next clock edge.
  task automatic model_step();
    bit found;
    int j;
    m_edge++;
    e_done = '0;
    if (m_busy) begin
      if (m_edge == m_start + 2 + m_w) begin
        e_done = N'(1) << m_owner;
        if (m_wr) mm[m_addr] = m_wdata;
        else      m_rdata    = mm[m_addr];
        m_rr   = (m_owner + 1) % N;
        m_busy = 1'b0;
      end
    end else if (req != '0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (!found && req[j]) begin
          found   = 1'b1;
          m_owner = j;
        end
      end
      m_busy  = 1'b1;
      m_start = m_edge;
      m_w     = wait_states;
      m_wr    = req_write[m_owner];
      m_addr  = req_addr[m_owner*AW +: AW];
      m_wdata = req_wdata[m_owner*DW +: DW];
    end
    e_psel  = m_busy;
    e_pen   = m_busy && (m_edge > m_start);
    e_grant = m_busy ? (N'(1) << m_owner) : '0;
  endtask

  initial begin
    logic [N-1:0] prev;
    int           ng;
    logic [DW-1:0] exp_rd;

    PRESET = 1'b1;
    req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    wait_states = 0;
    stuck = 1'b0;

    tbl[0] = '{0, 1'b1, 8'h10, 32'hDEAD_BEEF, 0, 1'b0, 3, 32'h0000_0000};
    tbl[1] = '{2, 1'b0, 8'h10, 32'h0000_0000, 0, 1'b0, 3, 32'hDEAD_BEEF};
    tbl[2] = '{1, 1'b1, 8'hFF, 32'h1234_5678, 2, 1'b0, 5, 32'hDEAD_BEEF};
    tbl[3] = '{3, 1'b0, 8'hFF, 32'h0000_0000, 1, 1'b0, 4, 32'h1234_5678};
    tbl[4] = '{3, 1'b1, 8'h80, 32'hA5A5_5A5A, 5, 1'b0, 8, 32'h1234_5678};
    tbl[5] = '{0, 1'b0, 8'h80, 32'h0000_0000, 0, 1'b0, 3, 32'hA5A5_5A5A};
    tbl[6] = '{1, 1'b1, 8'h00, 32'h0000_0000, 0, 1'b0, 3, 32'hA5A5_5A5A};
    tbl[7] = '{2, 1'b0, 8'h00, 32'h0000_0000, 3, 1'b0, 6, 32'h0000_0000};

    do_reset();
    chk("rst_grant", 64'(grant), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_done_err", 64'(done_err), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    repeat (3) @(posedge PCLK);
    #1;
    chk("idle_psel", 64'(PSEL), 64'(0));
    chk("idle_grant", 64'(grant), 64'(0));

    for (int t = 0; t < 8; t++) do_xfer(tbl[t]);

`ifdef APB_ARB_TIMEOUT_EN
    stuck = 1'b1;
    do_xfer('{2, 1'b0, 8'h10, 32'h0, 0, 1'b1, 18, 32'h0000_0000});
    stuck = 1'b0;
    race(4'b1001, 3);
`else
    do_xfer('{1, 1'b1, 8'h40, 32'h0BAD_F00D, 20, 1'b0, 23, 32'h0000_0000});
    race(4'b1001, 3);
`endif

    // Four persistent requesters: grants rotate every three cycles.
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 1'b0, 8'(i), '0);
    @(posedge PCLK); #1;
    req  = '1;
    prev = '0;
    ng   = 0;
    for (int e = 1; e <= 13; e++) begin
      @(posedge PCLK); #1;
      chk("cont_onehot", 64'($onehot0(grant)), 64'(1));
      if (grant != '0 && prev == '0) begin
        chk("cont_order", 64'(grant), 64'(N'(1) << (ng % N)));
        chk("cont_edge", 64'(e), 64'(1 + 3 * ng));
        ng++;
      end
      prev = grant;
    end
    chk("cont_count", 64'(ng), 64'(5));
    req = '0;
    repeat (4) @(posedge PCLK);
    #1;

    // Reset in the middle of a long ACCESS, with rr_ptr away from zero.
    exp_rd = init_word(0);
    do_xfer('{1, 1'b1, 8'h31, 32'h1111_2222, 0, 1'b0, 3, exp_rd});
    wait_states = 10;
    set_lane(3, 1'b0, 8'h30, '0);
    req = 4'b1000;
    repeat (4) @(posedge PCLK);
    #2;
    chk("pre_reset_penable", 64'(PENABLE), 64'(1));
    PRESET = 1'b1;
    #1;
    chk("mid_rst_psel", 64'(PSEL), 64'(0));
    chk("mid_rst_penable", 64'(PENABLE), 64'(0));
    chk("mid_rst_grant", 64'(grant), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_rdata", 64'(rdata), 64'(0));
    @(negedge PCLK);
    PRESET = 1'b0;
    race(4'b1001, 0);

    // Randomized traffic against the transaction-level model.
    do_reset();
    for (int i = 0; i < 256; i++) mm[i] = init_word(i);
    for (int i = 0; i < N; i++) r_pend[i] = 1'b0;
    m_busy = 1'b0; m_rr = 0; m_rdata = '0; m_edge = 0; m_owner = 0;
    m_start = 0; m_w = 0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      model_step();
      @(posedge PCLK); #1;
      chk("rnd_grant", 64'(grant), 64'(e_grant));
      chk("rnd_done", 64'(done), 64'(e_done));
      chk("rnd_psel", 64'(PSEL), 64'(e_psel));
      chk("rnd_penable", 64'(PENABLE), 64'(e_pen));
      chk("rnd_rdata", 64'(rdata), 64'(m_rdata));
      chk("rnd_done_err", 64'(done_err), 64'(0));
      if (e_psel) begin
        chk("rnd_paddr", 64'(PADDR), 64'(m_addr));
        chk("rnd_pwrite", 64'(PWRITE), 64'(m_wr));
        if (m_wr) chk("rnd_pwdata", 64'(PWDATA), 64'(m_wdata));
      end
      for (int i = 0; i < N; i++) begin
        if (e_done[i]) begin
          r_pend[i] = 1'b0;
          req[i]    = 1'b0;
        end else if (!r_pend[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            r_pend[i] = 1'b1;
            req[i]    = 1'b1;
            set_lane(i, 1'($urandom), 8'($urandom_range(0, 15)), $urandom);
          end
        end else if (m_busy && i == m_owner) begin
          if ($urandom_range(0, 5) == 0) set_lane(i, 1'($urandom), 8'($urandom), $urandom);
          if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
        end
      end
      if (e_done != '0) wait_states = int'($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_arbiter_master.md
Name: apb_arbiter_master

Overview:
- Round-robin arbiter and APB master that shares one APB slave (the 256x32 RAM slave) between NUM_REQ local requesters.
- Serialises requests into APB SETUP/ACCESS transfers, returns read data and a per-requester completion pulse.
- Sits between the datapath engines and the APB slave bus; it is the only master on that bus.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDRWIDTH, 8, APB address width
- DATAWIDTH, 32, APB data width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (used only with the optional feature)

Ports:
- PCLK  in  1  clock; all logic on posedge
- PRESET  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  request per requester; held high until its done pulse
- req_write  in  NUM_REQ  1=write, 0=read, per requester
- req_addr  in  NUM_REQ*ADDRWIDTH  packed addresses; slice i belongs to requester i
- req_wdata  in  NUM_REQ*DATAWIDTH  packed write data
- grant  out  NUM_REQ  one-hot; current owner, high from SETUP through the done cycle
- done  out  NUM_REQ  one-hot, 1-cycle pulse at transfer completion
- done_err  out  1  high with done if the transfer was aborted
- rdata  out  DATAWIDTH  read data; valid in the done cycle, held until the next done
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDRWIDTH  APB address
- PWDATA  out  DATAWIDTH  APB write data
- PRDATA  in  DATAWIDTH  APB read data
- PREADY  in  1  APB ready

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; rr_ptr=0.
- States: IDLE -> SETUP -> ACCESS -> IDLE.
- IDLE:
  - If any req is set, pick the first set bit searching from rr_ptr upward with wrap.
  - Latch that requester's index, write, addr and wdata into internal registers.
  - Assert grant; go to SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from the latched values; always exactly 1 cycle.
- ACCESS:
  - PSEL=1, PENABLE=1. PREADY is sampled only in this state.
  - On the posedge where PREADY=1: pulse done[idx]; capture PRDATA into rdata for reads (writes leave rdata unchanged); set rr_ptr=(idx+1) mod NUM_REQ; drop PSEL, PENABLE and grant; go to IDLE.
- Minimum transfer: IDLE, SETUP and ACCESS are 3 cycles from req to done; back-to-back transfers start every 3 cycles (one mandatory IDLE cycle between transfers).
- PADDR/PWRITE/PWDATA stay stable from SETUP to the end of ACCESS. Changes on the req_* inputs after latching are ignored.
- A requester dropping req mid-transfer does not abort the transfer; done still pulses.
- A requester must not re-assert req in the cycle it receives done if it wants a fresh transfer; req is level-sampled only in IDLE.
- Simultaneous requests are granted in round-robin order; a single persistent requester is granted every 3 cycles.
- When no req is set, outputs stay in idle values (PSEL=0, PENABLE=0, grant=0).

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN
- Defined:
  - A counter runs in ACCESS. If PREADY is not seen after TIMEOUT_CYCLES cycles, abort: done and done_err pulse together, rdata is unchanged, rr_ptr advances, state returns to IDLE.
  - The counter clears on entering ACCESS.
- Undefined: no counter; ACCESS waits indefinitely; done_err is tied 0.

Decomposition:
- Package apb_arb_pkg holds:
  - state encoding constants ST_IDLE=2'b00, ST_SETUP=2'b01, ST_ACCESS=2'b10
  - default widths
- Sub-module rr_picker: combinational, takes req and rr_ptr, returns a one-hot pick and its index.

Test Plan:
- Single write: req[0], addr 0x10, wdata 0xDEADBEEF -> SETUP then ACCESS with PADDR=0x10, PWRITE=1; done[0] 3 cycles after req; the slave stores the value.
- Read-back: req[2] read of 0x10 -> rdata=0xDEADBEEF in the done[2] cycle; PWRITE=0 throughout.
- Contention: req=4'b1111 held -> grants in order 0,1,2,3,0, each 3 cycles apart; no grant overlap.
- Wait states: PREADY held low 5 ACCESS cycles -> PADDR stable, done at the 6th ACCESS posedge.
- Reset mid-ACCESS: assert PRESET -> PSEL, PENABLE, grant and done are 0 immediately; after release, rr_ptr=0 and requester 0 wins.
- With APB_ARB_TIMEOUT_EN, PREADY stuck 0 -> done and done_err pulse after 16 ACCESS cycles; the next requester is then served.
